// File: rtl/axis_stream_monitor.sv
// Passive AXI4-Stream protocol monitor: handshake/payload stability, stall limit,
// TSTRB/TKEEP legality and per-TDEST packet statistics. Optional interleave check: AXIS_STREAM_MONITOR_INTERLEAVE_CHK_EN.
module axis_stream_monitor #(
  parameter int N             = 4,
  parameter int I             = 1,
  parameter int D             = 4,
  parameter int U             = 1,
  parameter int NUM_CH        = 4,
  parameter int MAXWAITS      = 16,
  parameter int MAX_PKT_BEATS = 1024,
  parameter int LEN_W         = 16,
  localparam int CH_W         = $clog2(NUM_CH),
  localparam int CHO_W        = (CH_W > 0) ? CH_W : 1,
`ifdef AXIS_STREAM_MONITOR_INTERLEAVE_CHK_EN
  localparam int E            = 7
`else
  localparam int E            = 6
`endif
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               tvalid,
  input  logic               tready,
  input  logic [8*N-1:0]     tdata,
  input  logic [N-1:0]       tstrb,
  input  logic [N-1:0]       tkeep,
  input  logic               tlast,
  input  logic [I-1:0]       tid,
  input  logic [D-1:0]       tdest,
  input  logic [U-1:0]       tuser,
  input  logic               clear,
  output logic [E-1:0]       err_pulse,
  output logic [E-1:0]       err_sticky,
  output logic [2:0]         first_err,
  output logic               pkt_done,
  output logic [LEN_W-1:0]   last_pkt_len,
  output logic [CHO_W-1:0]   last_pkt_ch,
  output logic [31:0]        pkt_count
);

  localparam int PW = 10*N + 1 + I + D + U;
  localparam int SW = (MAXWAITS > 0) ? $clog2(MAXWAITS + 1) : 1;

  logic [PW-1:0]    payload;
  logic [PW-1:0]    payload_reg;
  logic             hs;
  logic             pend;
  logic             pend_reg;
  logic             first_reg;
  logic [SW-1:0]    stall_reg;
  logic [CHO_W-1:0] ch;
  logic [LEN_W-1:0] beat_cnt [NUM_CH];
  logic [LEN_W-1:0] cur_cnt;
  logic [LEN_W-1:0] cur_sat;
  logic [LEN_W:0]   cur_inc;
  logic             len_over;
  logic             wait_hit;
  logic [E-1:0]     err_next;
  logic [2:0]       low_idx;

  assign payload = {tdata, tstrb, tkeep, tlast, tid, tdest, tuser};
  assign hs      = tvalid & tready;
  assign pend    = tvalid & ~tready;

  generate
    if (NUM_CH > 1) begin : g_idx
      assign ch = tdest[CHO_W-1:0];
    end else begin : g_one
      assign ch = '0;
    end
  endgenerate

  assign cur_cnt  = beat_cnt[ch];
  assign cur_inc  = {1'b0, cur_cnt} + (LEN_W+1)'(1);
  assign cur_sat  = (&cur_cnt) ? cur_cnt : cur_inc[LEN_W-1:0];
  assign len_over = cur_inc > (LEN_W+1)'(MAX_PKT_BEATS);
  // Fires on the stall cycle that brings the counter to MAXWAITS; saturation keeps it single-shot.
  assign wait_hit = (MAXWAITS != 0) && pend && (stall_reg == SW'(MAXWAITS - 1));

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [LEN_W-1:0] cnt_reg;
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          cnt_reg <= '0;
        end else if (hs && (ch == CHO_W'(gi))) begin
          cnt_reg <= tlast ? '0 : cur_sat;
        end
      end
      assign beat_cnt[gi] = cnt_reg;
    end
  endgenerate

`ifdef AXIS_STREAM_MONITOR_INTERLEAVE_CHK_EN
  logic [NUM_CH-1:0] open_reg;
  logic [NUM_CH-1:0] ch_onehot;
  logic              il_err;

  assign ch_onehot = NUM_CH'(1) << ch;
  assign il_err    = hs & (|(open_reg & ~ch_onehot));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      open_reg <= '0;
    end else if (hs) begin
      open_reg <= tlast ? (open_reg & ~ch_onehot) : (open_reg | ch_onehot);
    end
  end
`endif

  always_comb begin
    err_next    = '0;
    err_next[0] = pend_reg & ~tvalid;
    err_next[1] = pend_reg & tvalid & (payload != payload_reg);
    err_next[2] = wait_hit;
    err_next[3] = tvalid & (|(tstrb & ~tkeep));
    err_next[4] = hs & len_over;
    err_next[5] = first_reg & tvalid;
`ifdef AXIS_STREAM_MONITOR_INTERLEAVE_CHK_EN
    err_next[6] = il_err;
`endif
  end

  always_comb begin
    low_idx = '0;
    for (int k = E - 1; k >= 0; k--) begin
      if (err_next[k]) low_idx = 3'(k);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      first_reg    <= 1'b1;
      pend_reg     <= 1'b0;
      payload_reg  <= '0;
      stall_reg    <= '0;
      err_pulse    <= '0;
      err_sticky   <= '0;
      first_err    <= '0;
      pkt_done     <= 1'b0;
      last_pkt_len <= '0;
      last_pkt_ch  <= '0;
      pkt_count    <= '0;
    end else begin
      first_reg   <= 1'b0;
      pend_reg    <= pend;
      payload_reg <= payload;

      if (!tvalid || hs) begin
        stall_reg <= '0;
      end else if (stall_reg != SW'(MAXWAITS)) begin
        stall_reg <= stall_reg + SW'(1);
      end

      err_pulse  <= err_next;
      err_sticky <= clear ? err_next : (err_sticky | err_next);
      if ((err_next != '0) && ((err_sticky == '0) || clear)) begin
        first_err <= low_idx;
      end else if (clear) begin
        first_err <= '0;
      end

      pkt_done <= hs & tlast;
      // A packet completing in the clear cycle is kept, like a same-cycle error.
      if (hs && tlast) begin
        last_pkt_len <= cur_sat;
        last_pkt_ch  <= ch;
        if (clear) begin
          pkt_count <= 32'd1;
        end else if (pkt_count != 32'hFFFF_FFFF) begin
          pkt_count <= pkt_count + 32'd1;
        end
      end else if (clear) begin
        last_pkt_len <= '0;
        last_pkt_ch  <= '0;
        pkt_count    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_axis_stream_monitor.sv
// Directed bench for axis_stream_monitor (MAXWAITS=4, MAX_PKT_BEATS=8): vector table plus
// hand-written multi-cycle sequences.
module tb_axis_stream_monitor;

`ifdef AXIS_STREAM_MONITOR_INTERLEAVE_CHK_EN
  localparam int E = 7;
`else
  localparam int E = 6;
`endif

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        tvalid, tready, tlast, clear;
  logic [31:0] tdata;
  logic [3:0]  tstrb, tkeep, tdest;
  logic [0:0]  tid, tuser;
  logic [E-1:0] err_pulse, err_sticky;
  logic [2:0]  first_err;
  logic        pkt_done;
  logic [15:0] last_pkt_len;
  logic [1:0]  last_pkt_ch;
  logic [31:0] pkt_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 aclk = ~aclk;

  axis_stream_monitor #(
    .N(4), .I(1), .D(4), .U(1), .NUM_CH(4),
    .MAXWAITS(4), .MAX_PKT_BEATS(8), .LEN_W(16)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .tvalid(tvalid), .tready(tready), .tdata(tdata), .tstrb(tstrb), .tkeep(tkeep),
    .tlast(tlast), .tid(tid), .tdest(tdest), .tuser(tuser), .clear(clear),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .first_err(first_err),
    .pkt_done(pkt_done), .last_pkt_len(last_pkt_len), .last_pkt_ch(last_pkt_ch),
    .pkt_count(pkt_count)
  );

  typedef struct {
    logic        v, r;
    logic [31:0] data;
    logic [3:0]  strb, keep;
    logic        last;
    logic [3:0]  dest;
    logic        clr;
    logic [6:0]  pulse, sticky;
    logic [2:0]  ferr;
    logic        done;
    logic [15:0] len;
    logic [1:0]  ch;
    logic [31:0] cnt;
  } vec_t;

  typedef struct {
    logic [3:0]  dest;
    logic        last;
    logic        done;
    logic [15:0] len;
    logic [1:0]  ch;
    logic [31:0] cnt;
    logic        il;
  } beat_t;

  vec_t  tbl [25];
  beat_t alt [8];

  function automatic vec_t mk(input logic v, r, input logic [31:0] d, input logic [3:0] s, k,
                              input logic l, input logic [3:0] dst, input logic c,
                              input logic [6:0] p, st, input logic [2:0] fe, input logic dn,
                              input logic [15:0] ln, input logic [1:0] cc, input logic [31:0] ct);
    vec_t x;
    x.v = v; x.r = r; x.data = d; x.strb = s; x.keep = k; x.last = l; x.dest = dst; x.clr = c;
    x.pulse = p; x.sticky = st; x.ferr = fe; x.done = dn; x.len = ln; x.ch = cc; x.cnt = ct;
    return x;
  endfunction

  function automatic beat_t mb(input logic [3:0] dst, input logic l, dn, input logic [15:0] ln,
                               input logic [1:0] cc, input logic [31:0] ct, input logic il);
    beat_t b;
    b.dest = dst; b.last = l; b.done = dn; b.len = ln; b.ch = cc; b.cnt = ct; b.il = il;
    return b;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic v, r, input logic [31:0] d, input logic [3:0] s, k,
                       input logic l, input logic [3:0] dst, input logic c);
    tvalid = v; tready = r; tdata = d; tstrb = s; tkeep = k; tlast = l; tdest = dst; clear = c;
  endtask

  task automatic chk_pkt(input string nm, input logic dn, input logic [15:0] ln,
                         input logic [1:0] cc, input logic [31:0] ct);
    chk({nm, ".done"}, 64'(pkt_done), 64'(dn));
    chk({nm, ".len"},  64'(last_pkt_len), 64'(ln));
    chk({nm, ".ch"},   64'(last_pkt_ch), 64'(cc));
    chk({nm, ".cnt"},  64'(pkt_count), 64'(ct));
  endtask

  task automatic show(input string nm);
    $display("%s pulse=%h sticky=%h first=%0d done=%b len=%0d ch=%0d cnt=%0d",
             nm, err_pulse, err_sticky, first_err, pkt_done, last_pkt_len, last_pkt_ch, pkt_count);
  endtask

  initial begin
    tid = '0; tuser = '0;
    // columns: v r data strb keep last dest clr | pulse sticky ferr done len ch cnt
    tbl[0]  = mk(1,0,32'hA5A5A5A5,4'hF,4'hF,1,0,0, 7'h20,7'h20,5,0,0,0,0);
    tbl[1]  = mk(1,0,32'hA5A5A5A5,4'hF,4'hF,1,0,0, 7'h00,7'h20,5,0,0,0,0);
    tbl[2]  = mk(1,0,32'hA5A5A5A5,4'hF,4'hF,1,0,0, 7'h00,7'h20,5,0,0,0,0);
    tbl[3]  = mk(1,1,32'hA5A5A5A5,4'hF,4'hF,1,0,0, 7'h00,7'h20,5,1,1,0,1);
    tbl[4]  = mk(0,0,32'hA5A5A5A5,4'hF,4'hF,0,0,0, 7'h00,7'h20,5,0,1,0,1);
    tbl[5]  = mk(0,0,32'h00000000,4'hF,4'hF,0,0,1, 7'h00,7'h00,0,0,0,0,0);
    tbl[6]  = mk(1,0,32'hA5A5A5A5,4'hF,4'hF,0,0,0, 7'h00,7'h00,0,0,0,0,0);
    tbl[7]  = mk(1,0,32'h5A5A5A5A,4'hF,4'hF,0,0,0, 7'h02,7'h02,1,0,0,0,0);
    tbl[8]  = mk(0,0,32'h5A5A5A5A,4'hF,4'hF,0,0,0, 7'h01,7'h03,1,0,0,0,0);
    tbl[9]  = mk(0,0,32'h00000000,4'hF,4'hF,0,0,1, 7'h00,7'h00,0,0,0,0,0);
    for (int i = 10; i < 20; i++)
      tbl[i] = mk(1,0,32'h11111111,4'hF,4'hF,1,0,0, (i == 13) ? 7'h04 : 7'h00,
                  (i >= 13) ? 7'h04 : 7'h00, (i >= 13) ? 3'd2 : 3'd0, 0,0,0,0);
    tbl[20] = mk(1,1,32'h11111111,4'hF,4'hF,1,0,0, 7'h00,7'h04,2,1,1,0,1);
    tbl[21] = mk(0,0,32'h00000000,4'hF,4'hF,0,0,1, 7'h00,7'h00,0,0,0,0,0);
    tbl[22] = mk(1,1,32'h00000000,4'h3,4'h1,1,0,0, 7'h08,7'h08,3,1,1,0,1);
    tbl[23] = mk(0,0,32'h00000000,4'h3,4'h1,0,0,0, 7'h00,7'h08,3,0,1,0,1);
    tbl[24] = mk(0,0,32'h00000000,4'hF,4'hF,0,0,1, 7'h00,7'h00,0,0,0,0,0);

    // ch1 via tdest=9 (upper bits ignored), ch2 via tdest=2, alternating
    alt[0] = mb(4'h9,0, 0,0,0,0, 0);
    alt[1] = mb(4'h2,0, 0,0,0,0, 1);
    alt[2] = mb(4'h9,0, 0,0,0,0, 1);
    alt[3] = mb(4'h2,0, 0,0,0,0, 1);
    alt[4] = mb(4'h9,1, 1,3,1,1, 1);
    alt[5] = mb(4'h2,0, 0,3,1,1, 0);
    alt[6] = mb(4'h2,0, 0,3,1,1, 0);
    alt[7] = mb(4'h2,1, 1,5,2,2, 0);

    // Reset held with tvalid already high
    aresetn = 1'b0;
    drive(1,0,32'hA5A5A5A5,4'hF,4'hF,1,0,0);
    step(); step();
    show("reset");
    chk("rst.pulse",  64'(err_pulse), 64'd0);
    chk("rst.sticky", 64'(err_sticky), 64'd0);
    chk("rst.ferr",   64'(first_err), 64'd0);
    chk_pkt("rst", 0, 0, 0, 0);
    aresetn = 1'b1;

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].v, tbl[i].r, tbl[i].data, tbl[i].strb, tbl[i].keep,
            tbl[i].last, tbl[i].dest, tbl[i].clr);
      step();
      show($sformatf("row%0d", i));
      chk($sformatf("row%0d.pulse", i),  64'(err_pulse), 64'(tbl[i].pulse));
      chk($sformatf("row%0d.sticky", i), 64'(err_sticky), 64'(tbl[i].sticky));
      chk($sformatf("row%0d.ferr", i),   64'(first_err), 64'(tbl[i].ferr));
      chk_pkt($sformatf("row%0d", i), tbl[i].done, tbl[i].len, tbl[i].ch, tbl[i].cnt);
    end

    // Interleaved packets on two channels
    for (int i = 0; i < 8; i++) begin
      drive(1,1,32'(i),4'hF,4'hF,alt[i].last,alt[i].dest,0);
      step();
      show($sformatf("alt%0d", i));
      chk($sformatf("alt%0d.pulse", i), 64'(err_pulse[5:0]), 64'd0);
`ifdef AXIS_STREAM_MONITOR_INTERLEAVE_CHK_EN
      chk($sformatf("alt%0d.il", i), 64'(err_pulse[6]), 64'(alt[i].il));
`endif
      chk_pkt($sformatf("alt%0d", i), alt[i].done, alt[i].len, alt[i].ch, alt[i].cnt);
    end
    drive(0,0,0,4'hF,4'hF,0,0,1);
    step();
    show("clr");
    chk("clr.sticky", 64'(err_sticky), 64'd0);

    // 9-beat packet on ch3 against an 8-beat limit
    for (int k = 1; k <= 9; k++) begin
      drive(1,1,32'(k),4'hF,4'hF,(k == 9),4'h3,0);
      step();
      show($sformatf("long%0d", k));
      chk($sformatf("long%0d.pulse", k), 64'(err_pulse), (k == 9) ? 64'h10 : 64'h0);
    end
    chk_pkt("long", 1, 9, 3, 1);
    chk("long.ferr", 64'(first_err), 64'd4);

    // Drop a pending beat, then clear in the same cycle as a new error
    drive(1,0,32'h77,4'hF,4'hF,0,0,0);
    step();
    drive(0,0,32'h77,4'hF,4'hF,0,0,0);
    step();
    show("drop");
    chk("drop.pulse",  64'(err_pulse), 64'h01);
    chk("drop.sticky", 64'(err_sticky), 64'h11);
    drive(1,1,32'h0,4'h3,4'h1,1,0,1);
    step();
    show("clrerr");
    chk("clrerr.pulse",  64'(err_pulse), 64'h08);
    chk("clrerr.sticky", 64'(err_sticky), 64'h08);
    chk("clrerr.ferr",   64'(first_err), 64'd3);

    // Reset in the middle of a ch1 packet
    drive(1,1,32'h1,4'hF,4'hF,0,1,0);
    step(); step();
    drive(0,0,32'h0,4'hF,4'hF,0,1,0);
    aresetn = 1'b0;
    #1;
    show("midrst");
    chk("midrst.pulse",  64'(err_pulse), 64'd0);
    chk("midrst.sticky", 64'(err_sticky), 64'd0);
    chk_pkt("midrst", 0, 0, 0, 0);
    aresetn = 1'b1;
    step();
    chk("post.pulse", 64'(err_pulse), 64'd0);
    drive(1,1,32'h2,4'hF,4'hF,1,1,0);
    step();
    show("post");
    chk("post.pulse2", 64'(err_pulse), 64'd0);
    chk_pkt("post", 1, 1, 1, 1);

`ifdef AXIS_STREAM_MONITOR_INTERLEAVE_CHK_EN
    drive(1,1,32'h3,4'hF,4'hF,0,0,0);
    step();
    chk("il0.pulse", 64'(err_pulse), 64'd0);
    step();
    chk("il1.pulse", 64'(err_pulse), 64'd0);
    drive(1,1,32'h4,4'hF,4'hF,0,3,0);
    step();
    show("il");
    chk("il.pulse",  64'(err_pulse), 64'h40);
    chk("il.sticky", 64'(err_sticky), 64'h40);
    chk("il.ferr",   64'(first_err), 64'd6);
`endif

    drive(0,0,0,4'hF,4'hF,0,0,0);
    step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
